// File: rtl/param_pipe_reg_pkg.sv
// param_pipe_reg_pkg: shared defaults and width helper for the parametrised pipeline register.
`default_nettype none

package param_pipe_reg_pkg;

    localparam int PIPE_WIDTH_DEF = 32;
    localparam int PIPE_DEPTH_DEF = 2;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/param_pipe_reg_stage.sv
// pipe_stage: one valid/ready register stage; fills whenever empty or downstream is taking.
// Optional macro PARAM_PIPE_REG_FLUSH_EN adds a synchronous flush that clears the valid bit.
`default_nettype none

module pipe_stage
    import param_pipe_reg_pkg::*;
#(
    parameter int               WIDTH    = PIPE_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             resetn,
`ifdef PARAM_PIPE_REG_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_load;

    // Empty stages accept even when downstream is stalled, which collapses bubbles.
    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_ready && in_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_data  <= RST_DATA;
        end else begin
`ifdef PARAM_PIPE_REG_FLUSH_EN
            if (flush) begin
                r_valid <= 1'b0;
            end else if (in_ready) begin
                r_valid <= in_valid;
            end
`else
            if (in_ready) begin
                r_valid <= in_valid;
            end
`endif
            if (w_load) begin
                r_data <= in_data;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/param_pipe_reg.sv
// param_pipe_reg: DEPTH-stage valid/ready register chain with a registered occupancy count.
// Optional macro PARAM_PIPE_REG_FLUSH_EN adds a synchronous flush input.
`default_nettype none

module param_pipe_reg
    import param_pipe_reg_pkg::*;
#(
    parameter int               WIDTH    = PIPE_WIDTH_DEF,
    parameter int               DEPTH    = PIPE_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic                       clk,
    input  logic                       resetn,
`ifdef PARAM_PIPE_REG_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [occ_w(DEPTH)-1:0]    occupancy
);

    localparam int OCC_W = occ_w(DEPTH);

    // Index k is the input side of stage k; index DEPTH is the output interface.
    logic             w_valid [DEPTH+1];
    logic             w_ready [DEPTH+1];
    logic [WIDTH-1:0] w_data  [DEPTH+1];

    assign w_valid[0]     = s_valid;
    assign w_data[0]      = s_data;
    assign s_ready        = w_ready[0];
    assign m_valid        = w_valid[DEPTH];
    assign m_data         = w_data[DEPTH];
    assign w_ready[DEPTH] = m_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_stage #(
            .WIDTH    (WIDTH),
            .RST_DATA (RST_DATA)
        ) u_stage (
            .clk       (clk),
            .resetn    (resetn),
`ifdef PARAM_PIPE_REG_FLUSH_EN
            .flush     (flush),
`endif
            .in_valid  (w_valid[k]),
            .in_ready  (w_ready[k]),
            .in_data   (w_data[k]),
            .out_valid (w_valid[k+1]),
            .out_ready (w_ready[k+1]),
            .out_data  (w_data[k+1])
        );
    end

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [OCC_W-1:0] r_occ;

    assign w_in_xfer  = s_valid && s_ready;
    assign w_out_xfer = m_valid && m_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_occ <= '0;
        end else begin
`ifdef PARAM_PIPE_REG_FLUSH_EN
            if (flush) begin
                r_occ <= '0;
            end else if (w_in_xfer && !w_out_xfer) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!w_in_xfer && w_out_xfer) begin
                r_occ <= r_occ - OCC_W'(1);
            end
`else
            if (w_in_xfer && !w_out_xfer) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (!w_in_xfer && w_out_xfer) begin
                r_occ <= r_occ - OCC_W'(1);
            end
`endif
        end
    end

    assign occupancy = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_param_pipe_reg.sv
// tb_param_pipe_reg: directed and randomised scoreboard checks of param_pipe_reg (DEPTH 3, 1, 4).
`default_nettype none

module tb_param_pipe_reg;

    logic clk;
    logic resetn;

    // DUT A: WIDTH=32, DEPTH=3
    logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready;
    logic [31:0] a_s_data, a_m_data;
    logic [1:0]  a_occ;
    // DUT B: WIDTH=9, DEPTH=1
    logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready;
    logic [8:0]  b_s_data, b_m_data;
    logic [0:0]  b_occ;
    // DUT C: WIDTH=9, DEPTH=4
    logic        c_s_valid, c_s_ready, c_m_valid, c_m_ready;
    logic [8:0]  c_s_data, c_m_data;
    logic [2:0]  c_occ;

    logic [31:0] qa[$];
    logic [8:0]  qb[$];
    logic [8:0]  qc[$];

    int n_cmp = 0;
    int n_err = 0;

    param_pipe_reg #(.WIDTH(32), .DEPTH(3), .RST_DATA(32'h0)) u_a (
        .clk(clk), .resetn(resetn),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .occupancy(a_occ)
    );

    param_pipe_reg #(.WIDTH(9), .DEPTH(1), .RST_DATA(9'h0)) u_b (
        .clk(clk), .resetn(resetn),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .occupancy(b_occ)
    );

    param_pipe_reg #(.WIDTH(9), .DEPTH(4), .RST_DATA(9'h0)) u_c (
        .clk(clk), .resetn(resetn),
        .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
        .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
        .occupancy(c_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle of DUT A against the scoreboard: handshake sampled mid-cycle, occupancy after the edge.
    task automatic tick_a(input string tag);
        logic [63:0] exp_word;
        @(negedge clk);
        check({tag, ":s_ready"}, 64'(a_s_ready), 64'(!(qa.size() == 3 && !a_m_ready)));
        if (a_m_valid && a_m_ready) begin
            exp_word = (qa.size() > 0) ? 64'(qa.pop_front()) : '1;
            check({tag, ":m_data"}, 64'(a_m_data), exp_word);
        end
        if (a_s_valid && a_s_ready) qa.push_back(a_s_data);
        @(posedge clk);
        #1;
        check({tag, ":occ"}, 64'(a_occ), 64'(qa.size()));
    endtask

    initial begin
        logic [63:0] exp_word;
        resetn    = 1'b1;
        a_s_valid = 1'b0; a_m_ready = 1'b1; a_s_data = '0;
        b_s_valid = 1'b0; b_m_ready = 1'b0; b_s_data = '0;
        c_s_valid = 1'b0; c_m_ready = 1'b0; c_s_data = '0;

        // 1. reset and idle
        #1 resetn = 1'b0;
        #1;
        check("rst:m_valid", 64'(a_m_valid), 64'(0));
        check("rst:m_data",  64'(a_m_data),  64'(0));
        check("rst:occ",     64'(a_occ),     64'(0));
        check("rst:s_ready", 64'(a_s_ready), 64'(1));
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;
        tick_a("idle");
        tick_a("idle");
        check("idle:m_valid", 64'(a_m_valid), 64'(0));

        // 2. back-to-back stream, latency 3 edges to m_valid
        a_s_valid = 1'b1; a_s_data = 32'h11;
        tick_a("strm");
        check("strm:lat0", 64'(a_m_valid), 64'(0));
        a_s_data = 32'h22;
        tick_a("strm");
        check("strm:lat1", 64'(a_m_valid), 64'(0));
        a_s_data = 32'h33;
        tick_a("strm");
        check("strm:lat2_valid", 64'(a_m_valid), 64'(1));
        check("strm:lat2_data",  64'(a_m_data),  64'(32'h11));
        a_s_data = 32'h44;
        tick_a("strm");
        check("strm:occ_full", 64'(a_occ), 64'(3));
        a_s_valid = 1'b0;
        repeat (4) tick_a("strm_drain");
        check("strm:empty", 64'(a_m_valid), 64'(0));

        // 3. backpressure: three accepted, fourth refused, then drain in order
        a_m_ready = 1'b0; a_s_valid = 1'b1;
        a_s_data = 32'hA; tick_a("bp");
        a_s_data = 32'hB; tick_a("bp");
        a_s_data = 32'hC; tick_a("bp");
        a_s_data = 32'hD; tick_a("bp");
        check("bp:s_ready", 64'(a_s_ready), 64'(0));
        check("bp:occ",     64'(a_occ),     64'(3));
        check("bp:hold",    64'(a_m_data),  64'(32'hA));
        a_m_ready = 1'b1;
        tick_a("bp_rel");
        a_s_valid = 1'b0;
        repeat (4) tick_a("bp_drain");
        check("bp:empty", 64'(a_m_valid), 64'(0));

        // 4. full chain, simultaneous in and out
        a_m_ready = 1'b0; a_s_valid = 1'b1;
        a_s_data = 32'h1; tick_a("full");
        a_s_data = 32'h2; tick_a("full");
        a_s_data = 32'h3; tick_a("full");
        a_m_ready = 1'b1; a_s_data = 32'h55;
        tick_a("full_shift");
        check("full:occ",  64'(a_occ),    64'(3));
        check("full:head", 64'(a_m_data), 64'(32'h2));
        a_s_valid = 1'b0;
        repeat (4) tick_a("full_drain");

        // 5. asynchronous reset mid-stream
        a_s_valid = 1'b1;
        a_s_data = 32'h61; tick_a("ar");
        a_s_data = 32'h62; tick_a("ar");
        a_s_valid = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("ar:m_valid", 64'(a_m_valid), 64'(0));
        check("ar:occ",     64'(a_occ),     64'(0));
        check("ar:s_ready", 64'(a_s_ready), 64'(1));
        check("ar:m_data",  64'(a_m_data),  64'(0));
        qa.delete();
        @(negedge clk) resetn = 1'b1;
        @(posedge clk);
        #1;
        a_s_valid = 1'b1; a_s_data = 32'h77;
        tick_a("ar77");
        check("ar77:lat0", 64'(a_m_valid), 64'(0));
        a_s_valid = 1'b0;
        tick_a("ar77");
        check("ar77:lat1", 64'(a_m_valid), 64'(0));
        tick_a("ar77");
        check("ar77:valid", 64'(a_m_valid), 64'(1));
        check("ar77:data",  64'(a_m_data),  64'(32'h77));
        tick_a("ar77_drain");

        // 6. randomised valid/ready on DEPTH=1 and DEPTH=4
        for (int i = 0; i < 1000; i++) begin
            b_s_valid = 1'($urandom_range(0, 1));
            b_m_ready = 1'($urandom_range(0, 1));
            b_s_data  = 9'($urandom);
            c_s_valid = 1'($urandom_range(0, 1));
            c_m_ready = 1'($urandom_range(0, 1));
            c_s_data  = 9'($urandom);
            @(negedge clk);
            check("rndB:s_ready", 64'(b_s_ready), 64'(!(qb.size() == 1 && !b_m_ready)));
            if (b_m_valid && b_m_ready) begin
                exp_word = (qb.size() > 0) ? 64'(qb.pop_front()) : '1;
                check("rndB:m_data", 64'(b_m_data), exp_word);
            end
            if (b_s_valid && b_s_ready) qb.push_back(b_s_data);
            check("rndC:s_ready", 64'(c_s_ready), 64'(!(qc.size() == 4 && !c_m_ready)));
            if (c_m_valid && c_m_ready) begin
                exp_word = (qc.size() > 0) ? 64'(qc.pop_front()) : '1;
                check("rndC:m_data", 64'(c_m_data), exp_word);
            end
            if (c_s_valid && c_s_ready) qc.push_back(c_s_data);
            @(posedge clk);
            #1;
            check("rndB:occ", 64'(b_occ), 64'(qb.size()));
            check("rndC:occ", 64'(c_occ), 64'(qc.size()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
